rtmc_spi_master: RTL and testbench
==================================

Name: rtmc_spi_master

Overview:
SPI mode-0 initiator, the host-side counterpart of the chip's SPI target (sclk/cs/mosi in, miso out). It issues register read/write frames to the rtmc SPI target, both as a synthesizable bench/FPGA host and inside the test harness. It takes one frame word per valid/ready handshake, shifts it MSB-first on mosi while capturing miso, and returns the captured word with a one-cycle rx_valid strobe.

Parameters:
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
FRAME_BITS, 16, bits per chip-select frame (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  frame request
cmd_ready  output  1  block can accept a frame (high only in IDLE)
cmd_data  input  FRAME_BITS  word to transmit, MSB first
rx_valid  output  1  one-cycle strobe: rx_data holds the completed frame
rx_data  output  FRAME_BITS  word captured from miso, MSB first
busy  output  1  high in every state except IDLE
sclk  output  1  SPI clock, idles low
cs  output  1  chip select, active low, idles high
mosi  output  1  serial data to target
miso  input  1  serial data from target

Behaviour:
- Reset (async assert, sync release): state IDLE, sclk=0, cs=1, mosi=0, cmd_ready=1, busy=0, rx_valid=0, rx_data=0, counters cleared.
- Reset mid-frame: cs returns to 1 and sclk to 0 immediately (asynchronously). No rx_valid is issued.
- All outputs are registered. Frame timing is governed by a divider counter 0..CLK_DIV-1 and a bit counter 0..FRAME_BITS-1.
- IDLE:
  - Accept when cmd_valid && cmd_ready; cmd_data is latched into the shift register.
  - Next cycle: cs=0, mosi=cmd_data[FRAME_BITS-1], state SETUP.
- SETUP: hold for CLK_DIV cycles, then sclk=1, state HIGH.
- HIGH:
  - Hold sclk=1 for CLK_DIV cycles.
  - On the final cycle of the phase, shift miso into the rx shift register LSB.
  - If the bit counter is not at its last bit: sclk=0, mosi=next bit, state LOW.
  - Otherwise: sclk=0, mosi unchanged, state HOLD.
- LOW: hold CLK_DIV cycles, then sclk=1, state HIGH.
- HOLD: CLK_DIV cycles with sclk=0, then in the same cycle:
  - cs=1, rx_data = captured word, rx_valid=1 for exactly one cycle, state GAP.
- GAP: CLK_DIV cycles with cs=1, then IDLE.
- Timing rules:
  - cs is low for exactly CLK_DIV*(2*FRAME_BITS+1) cycles.
  - Exactly FRAME_BITS rising sclk edges per frame.
  - mosi changes only while sclk=0, or at cs assertion.
  - Minimum cs-high time between back-to-back frames is CLK_DIV+1 cycles.
- cmd_valid while busy: ignored, no queuing; the requester holds it until cmd_ready.
- cmd_data is sampled only at accept; later changes do not affect the frame in flight.
- rx_data holds its value until the next frame completes.
- FRAME_BITS=1: single HIGH phase, no LOW state visited.
- CLK_DIV=1: sclk period is 2 clk cycles; all rules above still hold.

Test Plan:
- Reset check: assert rst mid-IDLE and mid-frame. Required: cs=1, sclk=0, cmd_ready=1, busy=0, rx_valid=0 within the same cycle; no rx_valid afterward.
- Loopback (CLK_DIV=2, FRAME_BITS=16), miso tied to mosi, send 0xA5C3. Required:
  - cs low for 66 cycles, 16 sclk rising edges, mosi bits 1010_0101_1100_0011;
  - rx_valid one cycle coincident with cs rising, rx_data=0xA5C3.
- Target model returns 0x3C5A while host sends 0x0000. Required: rx_data=0x3C5A; mosi never changes while sclk=1.
- Back-to-back: cmd_valid held high with 0x1234 then 0xFFFF. Required:
  - two frames, cs high exactly CLK_DIV+1 cycles between them;
  - cmd_ready low throughout each frame;
  - rx_valid twice, with the correct captured words.
- Boundary parameters CLK_DIV=1, FRAME_BITS=1: send 1 with miso=1. Required: cs low 3 cycles, one sclk pulse of 1 cycle, rx_data=1.
- Busy drop: pulse cmd_valid for one cycle during HIGH state with data 0xBEEF. Required: request ignored, in-flight frame unchanged, no extra frame.

Source files
------------

// File: rtl/rtmc_spi_master.sv
// rtmc_spi_master: SPI mode-0 initiator issuing one chip-select frame per valid/ready handshake.
module rtmc_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FRAME_BITS-1:0] cmd_data,
    output logic                  rx_valid,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  busy,
    output logic                  sclk,
    output logic                  cs,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = FRAME_BITS > 1 ? $clog2(FRAME_BITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    state_t                r_state, w_state_n;
    logic [DW-1:0]         r_div, w_div_n;
    logic [BW-1:0]         r_bit, w_bit_n;
    logic [FRAME_BITS-1:0] r_tx, w_tx_n, r_rx, w_rx_n, r_rx_data, w_rx_data_n;
    logic                  r_sclk, w_sclk_n, r_cs, w_cs_n, r_mosi, w_mosi_n;
    logic                  r_rx_valid, w_rx_valid_n, r_ready, r_busy;
    logic                  w_div_done;

    assign w_div_done = r_div == DIV_LAST;

    always_comb begin
        w_state_n    = r_state;
        w_div_n      = w_div_done ? '0 : r_div + 1'b1;
        w_bit_n      = r_bit;
        w_tx_n       = r_tx;
        w_rx_n       = r_rx;
        w_rx_data_n  = r_rx_data;
        w_sclk_n     = r_sclk;
        w_cs_n       = r_cs;
        w_mosi_n     = r_mosi;
        w_rx_valid_n = 1'b0;
        case (r_state)
            IDLE: begin
                w_div_n = '0;
                if (cmd_valid && r_ready) begin
                    w_tx_n    = cmd_data << 1;
                    w_mosi_n  = cmd_data[FRAME_BITS-1];
                    w_cs_n    = 1'b0;
                    w_bit_n   = '0;
                    w_state_n = SETUP;
                end
            end
            SETUP, LOW: begin
                if (w_div_done) begin
                    w_sclk_n  = 1'b1;
                    w_state_n = HIGH;
                end
            end
            HIGH: begin
                if (w_div_done) begin
                    // miso is sampled at the end of the high phase, just before the falling edge
                    w_rx_n    = FRAME_BITS'({r_rx, miso});
                    w_sclk_n  = 1'b0;
                    w_state_n = r_bit == BIT_LAST ? HOLD : LOW;
                    if (r_bit != BIT_LAST) begin
                        w_mosi_n = r_tx[FRAME_BITS-1];
                        w_tx_n   = r_tx << 1;
                        w_bit_n  = r_bit + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_div_done) begin
                    w_cs_n       = 1'b1;
                    w_rx_data_n  = r_rx;
                    w_rx_valid_n = 1'b1;
                    w_state_n    = GAP;
                end
            end
            GAP: w_state_n = w_div_done ? IDLE : GAP;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_cs       <= 1'b1;
            r_mosi     <= 1'b0;
            r_rx_valid <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_div      <= w_div_n;
            r_bit      <= w_bit_n;
            r_tx       <= w_tx_n;
            r_rx       <= w_rx_n;
            r_rx_data  <= w_rx_data_n;
            r_sclk     <= w_sclk_n;
            r_cs       <= w_cs_n;
            r_mosi     <= w_mosi_n;
            r_rx_valid <= w_rx_valid_n;
            r_ready    <= w_state_n == IDLE;
            r_busy     <= w_state_n != IDLE;
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign rx_valid  = r_rx_valid;
    assign rx_data   = r_rx_data;
    assign sclk      = r_sclk;
    assign cs        = r_cs;
    assign mosi      = r_mosi;
endmodule

// File: tb/tb_rtmc_spi_master.sv
// tb_rtmc_spi_master: directed bench for the SPI initiator, 2/16 instance plus a 1/1 boundary instance.
module tb_rtmc_spi_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, rx_valid, busy, sclk, cs, mosi, miso;
    logic [15:0] cmd_data = '0, rx_data;
    logic        b_valid = 1'b0, b_ready, b_rx_valid, b_busy, b_sclk, b_cs, b_mosi;
    logic [0:0]  b_data = '0, b_rx_data;
    logic        loop = 1'b1;
    logic [15:0] tgt_word = '0, tgt = '0, mosi_bits = '0, got;
    int          total = 0, fails = 0;
    int          low_n = 0, hi_n = 0, frame_len = 0, last_gap = 0, frames = 0, rises = 0;
    int          mosi_bad = 0, ready_bad = 0, rxv_n = 0, rxv_bad = 0;
    logic        p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    int          b_low = 0, b_len = 0, b_rises = 0, b_hi = 0;
    logic        bp_cs = 1'b1, bp_sclk = 1'b0;
    int          r0, f0, v0, n;

    always #5 clk = ~clk;

    assign miso = loop ? mosi : tgt[15];

    rtmc_spi_master #(.CLK_DIV(2), .FRAME_BITS(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .sclk(sclk), .cs(cs),
        .mosi(mosi), .miso(miso)
    );

    rtmc_spi_master #(.CLK_DIV(1), .FRAME_BITS(1)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_data(b_data),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy), .sclk(b_sclk), .cs(b_cs),
        .mosi(b_mosi), .miso(1'b1)
    );

    // Bus monitor and mode-0 target model (shifts on falling sclk), sampled mid-cycle
    always @(negedge clk) begin
        if (p_cs && !cs) begin
            low_n = 0;
            last_gap = hi_n;
            frames++;
            tgt = tgt_word;
        end else if (p_sclk && !sclk) tgt = tgt << 1;
        if (!p_cs && cs) begin
            frame_len = low_n;
            hi_n = 0;
        end
        if (!cs) low_n++; else hi_n++;
        if (!p_sclk && sclk) begin
            rises++;
            mosi_bits = {mosi_bits[14:0], mosi};
        end
        if (p_sclk && sclk && mosi !== p_mosi) mosi_bad++;
        if (!cs && cmd_ready) ready_bad++;
        if (rx_valid) begin
            rxv_n++;
            if (!(cs && !p_cs)) rxv_bad++;
        end
        p_cs = cs;
        p_sclk = sclk;
        p_mosi = mosi;
    end

    always @(negedge clk) begin
        if (bp_cs && !b_cs) b_low = 0;
        if (!b_cs) b_low++;
        if (!bp_cs && b_cs) b_len = b_low;
        if (!bp_sclk && b_sclk) b_rises++;
        if (b_sclk) b_hi++;
        bp_cs = b_cs;
        bp_sclk = b_sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        int k = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = d;
        while (!cmd_ready && k < 400) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rx(input string tag, output logic [15:0] d);
        int k = 0;
        while (rx_valid !== 1'b1 && k < 400) begin
            @(negedge clk);
            #1 k++;
        end
        check({tag, "_timeout"}, 32'(k < 400), 32'd1);
        d = rx_data;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", cs, 1);
        check("rst_sclk", sclk, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rxv", rx_valid, 0);
        check("rst_rxd", rx_data, 0);
        check("rst_mosi", mosi, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        loop = 1'b1;
        r0 = rises;
        v0 = rxv_n;
        send(16'hA5C3);
        check("busy_in_frame", busy, 1);
        wait_rx("lb", got);
        check("lb_rxd", got, 16'hA5C3);
        check("lb_cs_low", frame_len, 66);
        check("lb_rises", rises - r0, 16);
        check("lb_mosi_bits", mosi_bits, 16'hA5C3);
        check("lb_rxv_cnt", rxv_n - v0, 1);
        check("lb_rxv_at_cs_rise", rxv_bad, 0);
        repeat (5) @(negedge clk);

        loop = 1'b0;
        tgt_word = 16'h3C5A;
        send(16'h0000);
        wait_rx("tgt", got);
        check("tgt_rxd", got, 16'h3C5A);
        check("tgt_mosi_bits", mosi_bits, 16'h0000);
        check("mosi_stable_high", mosi_bad, 0);
        repeat (20) @(negedge clk);
        #1 check("rxd_hold", rx_data, 16'h3C5A);

        loop = 1'b1;
        v0 = rxv_n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = 16'h1234;
        @(negedge clk);
        #1 cmd_data = 16'hFFFF;
        check("b2b_ready_low", cmd_ready, 0);
        wait_rx("b2b1", got);
        check("b2b1_rxd", got, 16'h1234);
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_rx("b2b2", got);
        check("b2b2_rxd", got, 16'hFFFF);
        check("b2b2_mosi_bits", mosi_bits, 16'hFFFF);
        check("b2b_gap", last_gap, 3);
        check("b2b_rxv_cnt", rxv_n - v0, 2);
        check("ready_low_in_frame", ready_bad, 0);
        repeat (5) @(negedge clk);

        f0 = frames;
        v0 = rxv_n;
        send(16'h1357);
        n = 0;
        while (!sclk && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1 cmd_valid = 1'b1;
        cmd_data = 16'hBEEF;
        @(negedge clk);
        #1 cmd_valid = 1'b0;
        wait_rx("drop", got);
        check("drop_rxd", got, 16'h1357);
        check("drop_mosi_bits", mosi_bits, 16'h1357);
        repeat (100) @(negedge clk);
        #1;
        check("drop_frames", frames - f0, 1);
        check("drop_rxv_cnt", rxv_n - v0, 1);
        check("drop_idle_cs", cs, 1);

        r0 = b_rises;
        n = b_hi;
        @(negedge clk);
        b_valid = 1'b1;
        b_data = 1'b1;
        @(posedge clk);
        #1 b_valid = 1'b0;
        v0 = 0;
        while (b_rx_valid !== 1'b1 && v0 < 50) begin
            @(negedge clk);
            #1 v0++;
        end
        check("bnd_timeout", 32'(v0 < 50), 1);
        check("bnd_rxd", b_rx_data, 1);
        check("bnd_cs_low", b_len, 3);
        check("bnd_rises", b_rises - r0, 1);
        check("bnd_sclk_high", b_hi - n, 1);
        repeat (5) @(negedge clk);

        #1 rst = 1'b1;
        #1;
        check("idle_rst_cs", cs, 1);
        check("idle_rst_ready", cmd_ready, 1);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        v0 = rxv_n;
        send(16'hA5C3);
        repeat (20) @(negedge clk);
        check("mid_cs_low", cs, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_cs", cs, 1);
        check("mid_rst_sclk", sclk, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rxv", rx_valid, 0);
        check("mid_rst_rxd", rx_data, 0);
        @(negedge clk) rst = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        check("mid_rst_no_rxv", rxv_n - v0, 0);
        check("mid_rst_idle_cs", cs, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
